// File: rtl/rv_pkg.sv
// Shared encodings for the writeback stage: result sources, load funct3 codes, FSM states.
package rv_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        WAIT_LD = 2'b01,
        WRITE   = 2'b10
    } state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction and sign/zero extension with misalignment detection.
module load_extend
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        misalign = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, half_sel};
                misalign = offset[0];
            end
            // LW and every unassigned encoding read the full word
            default: misalign = |offset;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: accepts instructions, waits for load data, drives the register-file write port.
module mem_wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic            m_reg_write,
    input  logic [4:0]      m_rd,
    input  logic [1:0]      m_result_src,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic [XLEN-1:0] m_pc_plus4,
    input  logic [2:0]      m_funct3,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            WE3,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            misalign,
    output logic            rsp_err,
    output logic [63:0]     instret
);

    state_t      state;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic            accept;
    logic            is_load;
    logic [XLEN-1:0] nl_result;
    logic            nl_we;
    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            ld_we;

    assign m_ready   = (state != WAIT_LD);
    assign accept    = m_valid & m_ready;
    assign is_load   = (m_result_src == RES_LOAD);
    assign nl_result = (m_result_src == RES_PC4) ? m_pc_plus4 : m_alu_result;
    assign nl_we     = m_reg_write & (m_rd != 5'd0);
    assign ld_we     = rw_q & (rd_q != 5'd0) & ~ld_mis;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .funct3  (f3_q),
        .offset  (off_q),
        .rdata   (dmem_rdata),
        .data    (ld_data),
        .misalign(ld_mis)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= EMPTY;
            rd_q     <= 5'd0;
            rw_q     <= 1'b0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            WE3      <= 1'b0;
            A3       <= 5'd0;
            WD3      <= '0;
            misalign <= 1'b0;
            rsp_err  <= 1'b0;
            instret  <= 64'd0;
        end else begin
            // Write-port outputs are single-cycle pulses; zero unless entering WRITE
            WE3      <= 1'b0;
            A3       <= 5'd0;
            WD3      <= '0;
            misalign <= 1'b0;
            if (dmem_rvalid && state != WAIT_LD) begin
                rsp_err <= 1'b1;
            end
            case (state)
                WAIT_LD: begin
                    if (dmem_rvalid) begin
                        state    <= WRITE;
                        WE3      <= ld_we;
                        A3       <= ld_we ? rd_q : 5'd0;
                        WD3      <= ld_we ? ld_data : '0;
                        misalign <= ld_mis;
                        instret  <= instret + 64'd1;
                    end
                end
                default: begin
                    if (accept && is_load) begin
                        state <= WAIT_LD;
                        rd_q  <= m_rd;
                        rw_q  <= m_reg_write;
                        f3_q  <= m_funct3;
                        off_q <= m_alu_result[1:0];
                    end else if (accept) begin
                        state   <= WRITE;
                        WE3     <= nl_we;
                        A3      <= nl_we ? m_rd : 5'd0;
                        WD3     <= nl_we ? nl_result : '0;
                        instret <= instret + 64'd1;
                    end else begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed scenarios followed by randomized traffic.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_write;
    logic [4:0]  m_rd;
    logic [1:0]  m_result_src;
    logic [31:0] m_alu_result;
    logic [31:0] m_pc_plus4;
    logic [2:0]  m_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        misalign;
    logic        rsp_err;
    logic [63:0] instret;

    mem_wb_stage #(
        .XLEN(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_reg_write (m_reg_write),
        .m_rd        (m_rd),
        .m_result_src(m_result_src),
        .m_alu_result(m_alu_result),
        .m_pc_plus4  (m_pc_plus4),
        .m_funct3    (m_funct3),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .WE3         (WE3),
        .A3          (A3),
        .WD3         (WD3),
        .misalign    (misalign),
        .rsp_err     (rsp_err),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              pending;
    logic [4:0]      p_rd;
    bit              p_rw;
    logic [2:0]      p_f3;
    logic [1:0]      p_off;
    bit              exp_err;
    longint unsigned exp_ret;

    bit              mon_en = 1'b0;
    longint unsigned mon_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {misaligned, data} from plain shift/mask arithmetic.
    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        logic        mis;
        case (f3)
            3'b000, 3'b100: begin
                v   = (rdata >> (int'(off) * 8)) & 32'hFF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
                mis = 1'b0;
            end
            3'b001, 3'b101: begin
                v   = (rdata >> (int'(off[1]) * 16)) & 32'hFFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
                mis = off[0];
            end
            default: begin
                v   = rdata;
                mis = (off != 2'd0);
            end
        endcase
        return {mis, v};
    endfunction

    task automatic push_exp(input bit rw, input logic [4:0] rd, input logic [31:0] val,
                            input bit mis);
        exp_t e;
        e.we  = rw && (rd != 5'd0) && !mis;
        e.a3  = e.we ? rd : 5'd0;
        e.wd3 = e.we ? val : 32'd0;
        e.mis = mis;
        sb.push_back(e);
        exp_ret++;
    endtask

    task automatic cycle(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input bit rv, input logic [31:0] rdata);
        logic [32:0] r;
        @(negedge clk);
        m_valid      = v;
        m_reg_write  = rw;
        m_rd         = rd;
        m_result_src = src;
        m_alu_result = alu;
        m_pc_plus4   = pc4;
        m_funct3     = f3;
        dmem_rvalid  = rv;
        dmem_rdata   = rdata;
        chk("m_ready", m_ready, !pending);
        if (pending) begin
            if (rv) begin
                r = model_load(p_f3, p_off, rdata);
                push_exp(p_rw, p_rd, r[31:0], r[32]);
                pending = 1'b0;
            end
        end else begin
            if (rv) exp_err = 1'b1;
            if (v) begin
                if (src == 2'b01) begin
                    pending = 1'b1;
                    p_rd    = rd;
                    p_rw    = rw;
                    p_f3    = f3;
                    p_off   = alu[1:0];
                end else begin
                    push_exp(rw, rd, (src == 2'b10) ? pc4 : alu, 1'b0);
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit with_accept);
        @(negedge clk);
        mon_en       = 1'b0;
        reset        = 1'b0;
        m_valid      = with_accept;
        m_reg_write  = 1'b1;
        m_rd         = 5'd7;
        m_result_src = 2'b00;
        m_alu_result = 32'h0000_DEAD;
        dmem_rvalid  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_we3", WE3, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_m_ready", m_ready, 1);
        sb.delete();
        pending = 1'b0;
        exp_err = 1'b0;
        exp_ret = 0;
        mon_cnt = 0;
        @(negedge clk);
        reset   = 1'b1;
        m_valid = 1'b0;
        mon_en  = 1'b1;
    endtask

    // Monitor: every instret step is one retirement and must match the next scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (instret != mon_cnt) begin
                mon_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: instret 0x%0h with empty scoreboard", instret);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_we3", WE3, mon_e.we);
                    chk("sb_a3", A3, mon_e.a3);
                    chk("sb_wd3", WD3, mon_e.wd3);
                    chk("sb_misalign", misalign, mon_e.mis);
                    chk("sb_instret", instret, mon_cnt);
                end
            end else begin
                chk("idle_we3", WE3, 0);
                chk("idle_a3", A3, 0);
                chk("idle_wd3", WD3, 0);
                chk("idle_misalign", misalign, 0);
            end
            chk("rsp_err", rsp_err, exp_err);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] src;
        bit         v;
        reset        = 1'b0;
        m_valid      = 1'b0;
        m_reg_write  = 1'b0;
        m_rd         = 5'd0;
        m_result_src = 2'b00;
        m_alu_result = 32'd0;
        m_pc_plus4   = 32'd0;
        m_funct3     = 3'd0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'd0;
        pending      = 1'b0;
        exp_err      = 1'b0;
        exp_ret      = 0;
        mon_cnt      = 0;
        do_reset(0);

        // ALU result to rd=5
        cycle(1, 1, 5, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 0, 0);
        #1;
        chk("alu_we3", WE3, 1);
        chk("alu_a3", A3, 5);
        chk("alu_wd3", WD3, 32'h1234_5678);
        chk("alu_instret", instret, 1);

        // PC+4 source to rd=1
        cycle(1, 1, 1, 2'b10, 32'h0000_AAAA, 32'h0000_0104, 3'd0, 0, 0);
        #1;
        chk("pc4_a3", A3, 1);
        chk("pc4_wd3", WD3, 32'h104);
        idle(1);

        // LB at offset 3, three stall cycles
        cycle(1, 1, 9, 2'b01, 32'h0000_1003, 32'h0, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_stall_ready", m_ready, 0);
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        #1;
        chk("lb_we3", WE3, 1);
        chk("lb_wd3", WD3, 32'hFFFF_FF80);

        // LHU then misaligned LW, from a reset that discards a same-cycle accept
        do_reset(1);
        cycle(1, 1, 10, 2'b01, 32'h0000_0002, 32'h0, 3'b101, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF_1234);
        #1;
        chk("lhu_wd3", WD3, 32'h0000_BEEF);
        cycle(1, 1, 11, 2'b01, 32'h0000_0001, 32'h0, 3'b010, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF);
        #1;
        chk("lw_mis_misalign", misalign, 1);
        chk("lw_mis_we3", WE3, 0);
        chk("lw_mis_instret", instret, 2);

        // Four back-to-back non-loads, one targeting x0
        cycle(1, 1, 3, 2'b00, 32'h0000_0003, 32'h0, 3'd0, 0, 0);
        #1; chk("b2b0_we3", WE3, 1);
        cycle(1, 1, 0, 2'b00, 32'h0000_0000, 32'h0, 3'd0, 0, 0);
        #1; chk("b2b1_we3", WE3, 0);
        cycle(1, 1, 4, 2'b10, 32'h0, 32'h0000_0044, 3'd0, 0, 0);
        #1; chk("b2b2_we3", WE3, 1);
        cycle(1, 1, 6, 2'b11, 32'h0000_0066, 32'h0, 3'd0, 0, 0);
        #1;
        chk("b2b3_we3", WE3, 1);
        chk("b2b3_wd3", WD3, 32'h66);
        chk("b2b_instret", instret, 6);
        idle(1);

        // Reset while waiting on a load, then a stray response
        cycle(1, 1, 12, 2'b01, 32'h0, 32'h0, 3'b010, 0, 0);
        idle(1);
        do_reset(0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        #1;
        chk("abandon_rsp_err", rsp_err, 1);
        chk("abandon_we3", WE3, 0);
        chk("abandon_instret", instret, 0);
        chk("abandon_ready", m_ready, 1);

        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            src = 2'($urandom);
            cycle(v, ($urandom_range(0, 7) != 0), 5'($urandom), src, $urandom, $urandom,
                  3'($urandom), pending && ($urandom_range(0, 2) == 0), $urandom);
        end
        while (pending) cycle(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
        idle(3);
        chk("sb_drained", sb.size(), 0);
        chk("final_instret", instret, exp_ret);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port m_valid  input  1  MEM stage presents an instruction.
REQ-005 SHALL have port m_ready  output  1  stage accepts this cycle; transfer occurs when m_valid and m_ready are both 1.
REQ-006 SHALL have port m_reg_write  input  1  instruction writes rd.
REQ-007 SHALL have port m_rd  input  5  destination register.
REQ-008 SHALL have port m_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
REQ-009 SHALL have ports m_alu_result and m_pc_plus4  input  XLEN each  candidate results; m_alu_result[1:0] is the load byte offset.
REQ-010 SHALL have port m_funct3  input  3  load width/sign selector.
REQ-011 SHALL have ports dmem_rvalid (input, 1) and dmem_rdata (input, XLEN)  load response from data memory.
REQ-012 SHALL have ports WE3 (output, 1), A3 (output, 5), WD3 (output, XLEN)  register-file write port.
REQ-013 SHALL have ports misalign (output, 1), rsp_err (output, 1), instret (output, 64)  status and retire count.

Function
REQ-014 SHALL implement FSM states EMPTY, WAIT_LD, WRITE.
REQ-015 SHALL drive m_ready = 1 in EMPTY and WRITE, 0 in WAIT_LD, decoded from state only.
REQ-016 On accept of a non-load: capture rd, reg_write, and selected result (ALU or PC+4); go to WRITE.
REQ-017 On accept of a load: capture rd, reg_write, funct3, offset; go to WAIT_LD.
REQ-018 In WAIT_LD with dmem_rvalid=1: extract, extend, and register the load data; go to WRITE. Without dmem_rvalid: stay indefinitely.
REQ-019 In WRITE: assert WE3 = captured reg_write AND rd != 0 for exactly that cycle; increment instret by 1; go to WRITE or WAIT_LD on a same-cycle accept, otherwise to EMPTY.
REQ-020 Latency SHALL be: non-load accepted at edge N gives WE3 high in cycle N+1; load rvalid sampled at edge K gives WE3 high in cycle K+1.
REQ-021 WD3 and A3 SHALL be register outputs, stable throughout WE3 high; WD3 = 0 and A3 = 0 whenever WE3 = 0.
REQ-022 Load extract: LB (000) and LBU (100) select byte offset*8; LH (001) and LHU (101) select half offset[1]*16; LW (010) selects full word; B/H/W sign-extend, BU/HU zero-extend; other funct3 values are treated as LW.
REQ-023 Misaligned load (LH/LHU with offset[0]=1, or LW with offset != 0): misalign SHALL pulse high in the WRITE cycle; the write is suppressed (WE3 = 0); instret still increments.
REQ-024 dmem_rvalid in EMPTY or WRITE SHALL be ignored and SHALL set sticky rsp_err.
REQ-025 instret SHALL wrap modulo 2^64.
REQ-026 rd = 0 SHALL never assert WE3.

Reset
REQ-027 While reset = 0 at a rising edge: state EMPTY, WE3 = 0, A3 = 0, WD3 = 0, misalign = 0, rsp_err = 0, instret = 0; an accept in that cycle is discarded.
REQ-028 Reset during WAIT_LD SHALL abandon the pending load; a later dmem_rvalid in EMPTY sets rsp_err.

Structure
REQ-029 The result_src encodings, funct3 load encodings, and FSM state encoding SHALL live in the shared package rv_pkg.
REQ-030 Load extraction/extension SHALL be a combinational sub-module load_extend (inputs: funct3, offset, rdata; outputs: data, misalign).

Verification
REQ-031 Accept ALU op, rd=5, result 0x1234_5678 at edge N: WE3=1, A3=5, WD3=0x12345678 in cycle N+1; instret=1.
REQ-032 Accept LB at offset 3, rvalid after 3 cycles with rdata 0x80FF_0000: m_ready=0 for 3 cycles; WD3=0xFFFF_FF80 one cycle after rvalid.
REQ-033 Accept LHU at offset 2 with rdata 0xBEEF_1234, then LW at offset 1: first gives WD3=0x0000_BEEF; second gives misalign=1, WE3=0, instret=2.
REQ-034 Back-to-back non-loads, m_valid held 4 cycles: four consecutive WE3 pulses, no bubbles; rd=0 entry gives WE3=0 but instret counts 4.
REQ-035 Reset asserted in WAIT_LD, rvalid arrives after release: state EMPTY, no write, rsp_err=1.
REQ-036 PC+4 source, rd=1, m_pc_plus4 = 0x0000_0104: WD3=0x104, A3=1.
